// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, stall/flush sequencing and perf counters
//
// Sequencing controller for a 5-stage pipeline (IF ID EX MEM WB) without
// forwarding. Control transfers resolve in MEM. A three-entry scoreboard
// mirrors the destination registers of the instructions in EX, MEM and WB.
// The scoreboard drives the stall and flush controls.
//
// Parameters:
//   WB_BYPASS  1: register file writes before it reads, so a WB producer is no hazard
//   CNT_W      width of the saturating stall/flush counters
//
// Ports:
//   clk_i          clock
//   rst_n          asynchronous active-low reset
//   id_rs_i/rt_i   source fields of the ID instruction
//   id_use_rs_i    ID instruction reads rs
//   id_use_rt_i    ID instruction reads rt
//   id_regwrite_i  ID instruction writes the register file
//   id_rd_i        final destination register of the ID instruction
//   mem_taken_i    redirect (taken branch / jump / jal / jr) in MEM
//   pc_write_o     PC load enable
//   ifid_write_o   IF/ID load enable
//   ifid_flush_o   load NOP into IF/ID
//   idex_flush_o   load bubble into ID/EX
//   exmem_flush_o  load bubble into EX/MEM
//   stall_cnt_o    saturating count of stall cycles
//   flush_cnt_o    saturating count of flush cycles

module hazard_ctrl #(
  parameter int unsigned WB_BYPASS = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_regwrite_i,
  input  logic [4:0]       id_rd_i,
  input  logic             mem_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam bit WB_HAZ = (WB_BYPASS == 0);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_e;

  // Scoreboard entries, one per downstream stage
  logic       sb_ex_v_q,  sb_ex_v_d;
  logic [4:0] sb_ex_rd_q, sb_ex_rd_d;
  logic       sb_mem_v_q,  sb_mem_v_d;
  logic [4:0] sb_mem_rd_q, sb_mem_rd_d;
  logic       sb_wb_v_q,  sb_wb_v_d;
  logic [4:0] sb_wb_rd_q, sb_wb_rd_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic  rs_match;
  logic  rt_match;
  logic  haz;
  mode_e mode;

  function automatic logic reg_match(
    input logic [4:0] r,
    input logic       ex_v,  input logic [4:0] ex_rd,
    input logic       mem_v, input logic [4:0] mem_rd,
    input logic       wb_v,  input logic [4:0] wb_rd
  );
    logic m;
    m = (ex_v && (ex_rd == r)) || (mem_v && (mem_rd == r)) ||
        (WB_HAZ && wb_v && (wb_rd == r));
    // $0 is hardwired, so nothing ever waits on it
    return (r != 5'd0) && m;
  endfunction

  always_comb begin
    rs_match = reg_match(id_rs_i, sb_ex_v_q, sb_ex_rd_q, sb_mem_v_q, sb_mem_rd_q,
                         sb_wb_v_q, sb_wb_rd_q);
    rt_match = reg_match(id_rt_i, sb_ex_v_q, sb_ex_rd_q, sb_mem_v_q, sb_mem_rd_q,
                         sb_wb_v_q, sb_wb_rd_q);
    haz      = (id_use_rs_i && rs_match) || (id_use_rt_i && rt_match);
  end

  // Mode select: a redirect kills younger work, so it outranks a stall.
  // While reset is held the pipeline must free-run regardless of inputs.
  always_comb begin
    mode = MODE_RUN;
    if (!rst_n) begin
      mode = MODE_RUN;
    end else if (mem_taken_i) begin
      mode = MODE_FLUSH;
    end else if (haz) begin
      mode = MODE_STALL;
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    unique case (mode)
      MODE_FLUSH: begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end
      MODE_STALL: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard next state. WB always takes MEM, so a jal in MEM keeps
  // its $31 write through a flush.
  always_comb begin
    sb_wb_v_d   = sb_mem_v_q;
    sb_wb_rd_d  = sb_mem_rd_q;
    sb_mem_v_d  = sb_ex_v_q;
    sb_mem_rd_d = sb_ex_rd_q;
    sb_ex_v_d   = 1'b0;
    sb_ex_rd_d  = 5'd0;
    unique case (mode)
      MODE_RUN: begin
        sb_ex_v_d  = id_regwrite_i && (id_rd_i != 5'd0);
        sb_ex_rd_d = id_rd_i;
      end
      MODE_FLUSH: begin
        sb_mem_v_d  = 1'b0;
        sb_mem_rd_d = 5'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mode == MODE_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((mode == MODE_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sb_ex_v_q   <= 1'b0;
      sb_ex_rd_q  <= 5'd0;
      sb_mem_v_q  <= 1'b0;
      sb_mem_rd_q <= 5'd0;
      sb_wb_v_q   <= 1'b0;
      sb_wb_rd_q  <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_ex_v_q   <= sb_ex_v_d;
      sb_ex_rd_q  <= sb_ex_rd_d;
      sb_mem_v_q  <= sb_mem_v_d;
      sb_mem_rd_q <= sb_mem_rd_d;
      sb_wb_v_q   <= sb_wb_v_d;
      sb_wb_rd_q  <= sb_wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU (IF, ID, EX, MEM, WB). Branches and jumps resolve in MEM, and the design has no forwarding.
The block keeps a scoreboard of in-flight destination registers. From it, the block generates the stall signals (PC and IF/ID write enables) and the flush signals for the IF/ID, ID/EX and EX/MEM pipeline registers.
It also keeps saturating counters of stall and flush cycles for performance checking.

Parameters:
WB_BYPASS, 0, 1 = the register file writes before it reads in the same cycle, so a producer in WB is not a hazard; 0 = a producer in WB is a hazard.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs_i  in  5  rs field of the instruction in ID
id_rt_i  in  5  rt field of the instruction in ID
id_use_rs_i  in  1  the ID instruction reads rs
id_use_rt_i  in  1  the ID instruction reads rt (R-type, beq/bne, sw)
id_regwrite_i  in  1  the ID instruction writes the register file
id_rd_i  in  5  final destination of the ID instruction (after RegDst/jal selection; 31 for jal)
mem_taken_i  in  1  taken branch, jump, jal or jr is in MEM this cycle
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID register load enable
ifid_flush_o  out  1  load NOP into IF/ID
idex_flush_o  out  1  load a bubble (all controls 0) into ID/EX
exmem_flush_o  out  1  load a bubble into EX/MEM
stall_cnt_o  out  CNT_W  count of stall cycles
flush_cnt_o  out  CNT_W  count of flush events

Behaviour:
- Scoreboard: three registered entries {v, rd}, named SB_EX, SB_MEM, SB_WB. Each entry mirrors the instruction currently in that stage.
- Reset (asynchronous, rst_n=0): all v=0, rd=0, both counters 0.
  - Outputs during reset: pc_write_o=1, ifid_write_o=1, all flush outputs 0.
- Match(r): true when r != 0 and any of the following holds:
  - SB_EX.v and SB_EX.rd == r;
  - SB_MEM.v and SB_MEM.rd == r;
  - WB_BYPASS == 0, SB_WB.v and SB_WB.rd == r.
- Raw hazard: haz = (id_use_rs_i & Match(id_rs_i)) | (id_use_rt_i & Match(id_rt_i)).
- Outputs are combinational from the current scoreboard state and inputs. Priority is flush > stall > run.
  - FLUSH (mem_taken_i=1):
    - ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1.
    - pc_write_o=1, ifid_write_o=1 (the PC loads the redirect target).
    - haz is ignored.
  - STALL (mem_taken_i=0, haz=1):
    - pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
    - ifid_flush_o=0, exmem_flush_o=0.
  - RUN (otherwise): pc_write_o=1, ifid_write_o=1, all flush outputs 0.
- Scoreboard update on each rising clock edge:
  - SB_WB <= SB_MEM in all modes.
  - RUN: SB_MEM <= SB_EX; SB_EX <= {id_regwrite_i & (id_rd_i != 0), id_rd_i}.
  - STALL: SB_MEM <= SB_EX; SB_EX <= {0, 0} (bubble).
  - FLUSH: SB_MEM <= {0, 0} (killed EX instruction); SB_EX <= {0, 0} (killed ID instruction).
  - A jal in MEM keeps its $31 write because it advances into SB_WB.
- Stall latency:
  - Dependent instruction immediately after its producer: 3 stall cycles (WB_BYPASS=0) or 2 (WB_BYPASS=1).
  - One independent instruction between producer and consumer: 2 or 1 stall cycles respectively.
- Counters:
  - stall_cnt_o increments by 1 on each STALL cycle.
  - flush_cnt_o increments by 1 on each FLUSH cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: an asynchronous clear of the scoreboard and counters. There is no pending stall after reset release.
- Register $0 is never a hazard. An instruction with id_rd_i=0 never enters the scoreboard as valid.

Test Plan:
- Cycle 0: ID = add with id_regwrite_i=1, id_rd_i=3. Cycle 1: ID uses rs=3, WB_BYPASS=0 -> stall in cycles 1-3 (pc_write_o=0, idex_flush_o=1); RUN in cycle 4; stall_cnt_o=3.
- Same sequence with WB_BYPASS=1 -> stall in cycles 1-2; stall_cnt_o=2.
- Producer with id_rd_i=0, consumer uses rs=0 -> no stall; SB_EX.v=0.
- Consumer stalled on $5 while mem_taken_i=1 -> all three flush outputs 1, pc_write_o=1, no stall; next cycle SB_EX.v=0 and SB_MEM.v=0; flush_cnt_o=1, stall_cnt_o unchanged.
- jal in MEM (SB_MEM={1,31}) with mem_taken_i=1, then ID reads rt=31 on the next cycle -> stall for 1 cycle (the WB match, WB_BYPASS=0), then RUN.
- CNT_W=4, 17 consecutive stall cycles -> stall_cnt_o holds at 15. Then rst_n=0 asserted mid-stall -> counters read 0 and pc_write_o=1 immediately, before any clock edge.
